// File: rtl/datapath_pkg.sv
// Shared types and constants for the pipelined datapath.
//   alu_op_e   : ALU operation encoding (codes 8-15 pass B)
//   pc_op_e    : PC operation encoding (codes 5-7 behave as increment)
//   dp_state_e : control FSM state (run / memory wait)
//   *_IDX      : bit positions of {C,V,Z,N} in the flags vector
package datapath_pkg;

    typedef enum logic [3:0] {
        AluAdd = 4'd0,
        AluAdc = 4'd1,
        AluSub = 4'd2,
        AluAnd = 4'd3,
        AluOr  = 4'd4,
        AluXor = 4'd5,
        AluShl = 4'd6,
        AluShr = 4'd7
    } alu_op_e;

    typedef enum logic [2:0] {
        PcInc  = 3'd0,
        PcJmp  = 3'd1,
        PcBcs  = 3'd2,
        PcCall = 3'd3,
        PcRet  = 3'd4
    } pc_op_e;

    typedef enum logic {
        StRun = 1'b0,
        StMem = 1'b1
    } dp_state_e;

    localparam int unsigned C_IDX = 3;
    localparam int unsigned V_IDX = 2;
    localparam int unsigned Z_IDX = 1;
    localparam int unsigned N_IDX = 0;

endpackage

// File: rtl/dp_alu.sv
// Combinational ALU and shifter.
//   a_i, b_i  : operands
//   op_i      : operation (alu_op_e, 8-15 pass B)
//   c_i       : current carry flag (ADC carry-in, kept by non-arith ops and zero shifts)
//   res_o     : result, mod 2^DW
//   flags_o   : {C,V,Z,N} computed from this operation
module dp_alu
    import datapath_pkg::*;
#(
    parameter int unsigned DW = 8
) (
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    input  logic [3:0]    op_i,
    input  logic          c_i,
    output logic [DW-1:0] res_o,
    output logic [3:0]    flags_o
);

    localparam int unsigned SW = $clog2(DW);

    logic [SW-1:0] amt;
    logic [DW:0]   sum;
    logic [DW:0]   shl;
    logic [DW:0]   shr;
    logic          c;
    logic          v;

    assign amt = b_i[SW-1:0];
    // One extra bit catches the last bit shifted out on either side.
    assign shl = {1'b0, a_i} << amt;
    assign shr = {a_i, 1'b0} >> amt;

    always_comb begin
        res_o = b_i;
        c     = c_i;
        v     = 1'b0;
        sum   = '0;
        case (op_i)
            AluAdd, AluAdc: begin
                sum   = {1'b0, a_i} + {1'b0, b_i}
                        + {{DW{1'b0}}, (op_i == AluAdc) ? c_i : 1'b0};
                res_o = sum[DW-1:0];
                c     = sum[DW];
                v     = (a_i[DW-1] == b_i[DW-1]) && (res_o[DW-1] != a_i[DW-1]);
            end
            AluSub: begin
                sum   = {1'b0, a_i} - {1'b0, b_i};
                res_o = sum[DW-1:0];
                c     = ~sum[DW];  // carry means no borrow
                v     = (a_i[DW-1] != b_i[DW-1]) && (res_o[DW-1] != a_i[DW-1]);
            end
            AluAnd: res_o = a_i & b_i;
            AluOr:  res_o = a_i | b_i;
            AluXor: res_o = a_i ^ b_i;
            AluShl: begin
                res_o = shl[DW-1:0];
                if (amt != '0) c = shl[DW];
            end
            AluShr: begin
                res_o = shr[DW:1];
                if (amt != '0) c = shr[0];
            end
            default: res_o = b_i;
        endcase
        flags_o        = '0;
        flags_o[C_IDX] = c;
        flags_o[V_IDX] = v;
        flags_o[Z_IDX] = (res_o == '0);
        flags_o[N_IDX] = res_o[DW-1];
    end

endmodule

// File: rtl/pipelined_datapath.sv
// Two-stage (EX/WB) datapath: register file with WB->EX forwarding, ALU, flags, PC/LR and a
// req/ack data-memory port that stalls the instruction stream while a load/store is pending.
//   clk, reset              : clock (rising edge), asynchronous active-high reset
//   in_valid_i/in_ready_o   : instruction handshake; flush_i squashes the presented instruction
//   rn/rm/rd_addr_i, imm_val_i, use_imm_i, alu_op_i, pc_op_i, wr_en_i, flag_we_i, ld_i, st_i
//                           : decoded instruction fields
//   mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o, mem_rdata_i/mem_ack_i : data-memory port
//   pc_o, lr_o, flags_o ({C,V,Z,N}), busy_o
module pipelined_datapath
    import datapath_pkg::*;
#(
    parameter  int unsigned DW    = 8,
    parameter  int unsigned AW    = 16,
    parameter  int unsigned NREGS = 16,
    localparam int unsigned RA    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic          flush_i,
    input  logic [RA-1:0] rn_addr_i,
    input  logic [RA-1:0] rm_addr_i,
    input  logic [RA-1:0] rd_addr_i,
    input  logic [DW-1:0] imm_val_i,
    input  logic          use_imm_i,
    input  logic [3:0]    alu_op_i,
    input  logic [2:0]    pc_op_i,
    input  logic          wr_en_i,
    input  logic          flag_we_i,
    input  logic          ld_i,
    input  logic          st_i,
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i,
    input  logic          mem_ack_i,
    output logic [AW-1:0] pc_o,
    output logic [AW-1:0] lr_o,
    output logic [3:0]    flags_o,
    output logic          busy_o
);

    logic [DW-1:0]   regs_q [NREGS];
    logic            wb_valid_q;
    logic [RA-1:0]   wb_rd_q;
    logic [DW-1:0]   wb_data_q;
    dp_state_e       state_q;
    logic            mem_req_q;
    logic            mem_we_q;
    logic [AW-1:0]   mem_addr_q;
    logic [DW-1:0]   mem_wdata_q;
    logic [RA-1:0]   mem_rd_q;
    logic [AW-1:0]   pc_q;
    logic [AW-1:0]   lr_q;
    logic [3:0]      flags_q;

    logic [DW-1:0]   op_a;
    logic [DW-1:0]   op_b;
    logic [DW-1:0]   op_d;
    logic [DW-1:0]   alu_res;
    logic [3:0]      alu_flags;
    logic [2*DW-1:0] ab_cat;
    logic [AW-1:0]   pc_inc;
    logic            accept;
    logic            is_mem;

    assign in_ready_o = (state_q == StRun);
    assign accept     = in_valid_i & in_ready_o & ~flush_i;
    assign is_mem     = ld_i | st_i;

    // Operand reads bypass the register file when WB is about to write the same register.
    always_comb begin
        op_a = regs_q[rn_addr_i];
        if (wb_valid_q && (wb_rd_q == rn_addr_i)) op_a = wb_data_q;
        op_b = regs_q[rm_addr_i];
        if (wb_valid_q && (wb_rd_q == rm_addr_i)) op_b = wb_data_q;
        if (use_imm_i) op_b = imm_val_i;
        op_d = regs_q[rd_addr_i];
        if (wb_valid_q && (wb_rd_q == rd_addr_i)) op_d = wb_data_q;
    end

    assign ab_cat = {op_a, op_b};
    assign pc_inc = pc_q + AW'(1);

    dp_alu #(
        .DW(DW)
    ) u_alu (
        .a_i    (op_a),
        .b_i    (op_b),
        .op_i   (alu_op_i),
        .c_i    (flags_q[C_IDX]),
        .res_o  (alu_res),
        .flags_o(alu_flags)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NREGS); i++) regs_q[i] <= '0;
        end else if (wb_valid_q) begin
            regs_q[wb_rd_q] <= wb_data_q;
        end
    end

    // WB holds at most one result: an ALU result at accept, or load data at mem_ack.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
        end else if (accept && !is_mem && wr_en_i) begin
            wb_valid_q <= 1'b1;
            wb_rd_q    <= rd_addr_i;
            wb_data_q  <= alu_res;
        end else if ((state_q == StMem) && mem_ack_i && !mem_we_q) begin
            wb_valid_q <= 1'b1;
            wb_rd_q    <= mem_rd_q;
            wb_data_q  <= mem_rdata_i;
        end else begin
            wb_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StRun;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_rd_q    <= '0;
        end else begin
            case (state_q)
                StRun: begin
                    if (accept && is_mem) begin
                        state_q     <= StMem;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= ~ld_i;  // ld wins if both are set
                        mem_addr_q  <= ab_cat[AW-1:0];
                        mem_wdata_q <= op_d;
                        mem_rd_q    <= rd_addr_i;
                    end
                end
                StMem: begin
                    if (mem_ack_i) begin
                        state_q   <= StRun;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                    end
                end
                default: state_q <= StRun;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= '0;
            lr_q    <= '0;
            flags_q <= '0;
        end else if (accept) begin
            if (flag_we_i) flags_q <= alu_flags;
            case (pc_op_i)
                PcJmp: pc_q <= ab_cat[AW-1:0];
                // Branch tests the carry from before this instruction's own flag update.
                PcBcs: pc_q <= flags_q[C_IDX] ? pc_q + AW'($signed(imm_val_i)) : pc_inc;
                PcCall: begin
                    lr_q <= pc_inc;
                    pc_q <= ab_cat[AW-1:0];
                end
                PcRet:   pc_q <= lr_q;
                default: pc_q <= pc_inc;
            endcase
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign pc_o        = pc_q;
    assign lr_o        = lr_q;
    assign flags_o     = flags_q;
    assign busy_o      = (state_q == StMem);

endmodule
